// File: rtl/sum_window_acc_if.sv
// Stream bundle between a sample source/result sink and sum_window_acc.
// The master side is the environment; the slave side is the accumulator.
interface sum_window_acc_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic [7:0]  out_avg;
    logic [7:0]  out_max;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_avg, out_max
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_avg, out_max
    );
endinterface

// File: rtl/sum_window_acc.sv
// Collects N = 2^WIN_LOG2 unsigned 8-bit samples and presents their sum,
// truncated average and maximum until the downstream side takes them.
//
// state   | meaning
// S_IDLE  | no sample of the current window taken yet
// S_ACCUM | 1..N-1 samples taken, r_left = samples still to go minus one
// S_HOLD  | result registered and offered on out_valid
module sum_window_acc #(
    parameter int WIN_LOG2 = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            clear,
    sum_window_acc_if.slave bus
);

    localparam int N     = 1 << WIN_LOG2;
    localparam int ACC_W = 8 + WIN_LOG2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_run;
    logic [WIN_LOG2-1:0] r_left;
    logic [ACC_W-1:0]    r_acc;
    logic [7:0]          r_max;
    logic [11:0]         r_out_sum;
    logic [7:0]          r_out_avg;
    logic [7:0]          r_out_max;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_xfer;
    logic [ACC_W-1:0]    w_acc_sum;
    logic [7:0]          w_max_upd;

    assign w_xfer    = w_in_ready & bus.in_valid;
    assign w_acc_sum = r_acc + ACC_W'(bus.in_data);
    assign w_max_upd = (bus.in_data > r_max) ? bus.in_data : r_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_xfer) w_state_nxt = S_ACCUM;
                S_ACCUM: if (w_xfer && (r_left == '0)) w_state_nxt = S_HOLD;
                S_HOLD:  if (bus.out_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // r_run keeps in_ready low until the first edge after reset release.
    always_comb begin
        w_in_ready  = r_run & ena & ~clear & (r_state != S_HOLD);
        w_out_valid = (r_state == S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run     <= 1'b0;
            r_left    <= '0;
            r_acc     <= '0;
            r_max     <= '0;
            r_out_sum <= '0;
            r_out_avg <= '0;
            r_out_max <= '0;
        end else begin
            r_run <= 1'b1;
            if (clear) begin
                r_left    <= '0;
                r_acc     <= '0;
                r_max     <= '0;
                r_out_sum <= '0;
                r_out_avg <= '0;
                r_out_max <= '0;
            end else if (w_xfer) begin
                if (r_state == S_IDLE) begin
                    r_acc  <= ACC_W'(bus.in_data);
                    r_max  <= bus.in_data;
                    r_left <= WIN_LOG2'(N - 2);
                end else if (r_left == '0) begin
                    r_out_sum <= 12'(w_acc_sum);
                    r_out_avg <= 8'(w_acc_sum >> WIN_LOG2);
                    r_out_max <= w_max_upd;
                    r_acc     <= '0;
                    r_max     <= '0;
                end else begin
                    r_acc  <= w_acc_sum;
                    r_max  <= w_max_upd;
                    r_left <= r_left - WIN_LOG2'(1);
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_avg   = r_out_avg;
    assign bus.out_max   = r_out_max;

endmodule

// File: tb/tb_sum_window_acc.sv
// Directed and randomized bench for sum_window_acc (WIN_LOG2 = 2) with a
// window-level reference model built from a sample queue.
module tb_sum_window_acc;

    localparam int WL = 2;
    localparam int N  = 1 << WL;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic ena   = 1'b0;
    logic clear = 1'b0;

    sum_window_acc_if bus ();

    sum_window_acc #(.WIN_LOG2(WL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int q[$];
    bit m_hold = 1'b0;
    bit m_run  = 1'b0;
    int m_sum  = 0;
    int m_avg  = 0;
    int m_max  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at edge+1, check at the falling edge, then advance the model.
    task automatic cycle(input bit e, input bit c, input bit v, input logic [7:0] d, input bit ordy);
        bit exp_rdy;
        bit xf;
        ena          = e;
        clear        = c;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.out_ready = ordy;
        @(negedge clk);
        exp_rdy = m_run && e && !m_hold && !c;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(m_hold));
        if (m_hold) begin
            chk("out_sum", 32'(bus.out_sum), m_sum);
            chk("out_avg", 32'(bus.out_avg), m_avg);
            chk("out_max", 32'(bus.out_max), m_max);
        end
        xf = exp_rdy && v;
        if (c) begin
            q.delete();
            m_hold = 1'b0;
        end else if (m_hold && ordy) begin
            m_hold = 1'b0;
        end else if (xf) begin
            q.push_back(int'(d));
            if (q.size() == N) begin
                m_sum = 0;
                m_max = 0;
                foreach (q[i]) begin
                    m_sum += q[i];
                    if (q[i] > m_max) m_max = q[i];
                end
                m_avg  = m_sum / N;
                m_hold = 1'b1;
                q.delete();
            end
        end
        m_run = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input int s, input int a, input int m);
        chk({tag, "_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_sum"}, 32'(bus.out_sum), s);
        chk({tag, "_avg"}, 32'(bus.out_avg), a);
        chk({tag, "_max"}, 32'(bus.out_max), m);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_sum", 32'(bus.out_sum), 0);
        chk("rst_out_avg", 32'(bus.out_avg), 0);
        chk("rst_out_max", 32'(bus.out_max), 0);
        q.delete();
        m_hold = 1'b0;
        m_run  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.out_ready = 1'b0;
        #1;
        reset_pulse();
        cycle(1, 0, 0, 8'd0, 0);

        // Basic window with immediate acceptance.
        cycle(1, 0, 1, 8'd10, 1);
        cycle(1, 0, 1, 8'd20, 1);
        cycle(1, 0, 1, 8'd30, 1);
        cycle(1, 0, 1, 8'd40, 1);
        chk_res("w1", 100, 25, 40);
        chk("w1_in_ready", 32'(bus.in_ready), 0);
        cycle(1, 0, 0, 8'd0, 1);
        cycle(1, 0, 0, 8'd0, 0);

        // Full-scale samples, then held result with out_ready low.
        for (int i = 0; i < N; i++) cycle(1, 0, 1, 8'd255, 0);
        chk_res("w255", 1020, 255, 255);
        for (int i = 0; i < 5; i++) cycle(1, 0, 1, 8'($urandom_range(255)), 0);
        chk_res("w255_held", 1020, 255, 255);
        cycle(1, 0, 1, 8'd77, 1);
        cycle(1, 0, 0, 8'd0, 0);

        // Abort a partial window with clear, overlapping a valid sample.
        cycle(1, 0, 1, 8'd7, 0);
        cycle(1, 0, 1, 8'd9, 0);
        cycle(1, 1, 1, 8'd50, 0);
        for (int i = 0; i < N; i++) cycle(1, 0, 1, 8'd1, 0);
        chk_res("w_clr", 4, 1, 1);
        // ena low must not block the output handshake.
        cycle(0, 0, 1, 8'd0, 1);
        cycle(1, 0, 0, 8'd0, 0);

        // Reset while holding a result.
        for (int i = 0; i < N; i++) cycle(1, 0, 1, 8'd60, 0);
        chk_res("w_pre_rst", 240, 60, 60);
        reset_pulse();
        cycle(1, 0, 1, 8'd99, 0);
        cycle(1, 0, 1, 8'd3, 0);
        cycle(1, 0, 1, 8'd3, 0);
        cycle(1, 0, 1, 8'd3, 0);
        cycle(1, 0, 1, 8'd5, 0);
        chk_res("w_rst", 14, 3, 5);
        // Clear while holding, even with out_ready high.
        cycle(1, 1, 0, 8'd0, 1);
        chk("clr_hold_valid", 32'(bus.out_valid), 0);

        // Stall mid-window with ena low and in_valid high.
        cycle(1, 0, 1, 8'd11, 0);
        cycle(1, 0, 1, 8'd22, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 8'd200, 0);
        cycle(1, 0, 1, 8'd33, 0);
        cycle(1, 0, 1, 8'd44, 0);
        chk_res("w_stall", 110, 27, 44);
        cycle(1, 0, 0, 8'd0, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(3) != 0, $urandom_range(24) == 0,
                  $urandom_range(3) != 0, 8'($urandom_range(255)),
                  $urandom_range(2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sum_window_acc.md
SUM_WINDOW_ACC -- requirements
Module: sum_window_acc

Interface
REQ-001 The block SHALL take parameter WIN_LOG2, default 2, meaning window length N = 2^WIN_LOG2 samples; legal range 1..4.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low; one clock, async active-low reset (decided).
REQ-004 The block SHALL have port ena  input  1  enable; low stalls intake, state held.
REQ-005 The block SHALL have port clear  input  1  synchronous window abort.
REQ-006 The block SHALL have port in_valid  input  1  upstream sample valid.
REQ-007 The block SHALL have port in_data  input  8  upstream 8-bit sum sample, unsigned.
REQ-008 The block SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-009 The block SHALL have port out_valid  output  1  window result valid.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 The block SHALL have port out_sum  output  12  window sum, zero-extended.
REQ-012 The block SHALL have port out_avg  output  8  out_sum >> WIN_LOG2, truncating.
REQ-013 The block SHALL have port out_max  output  8  largest sample in window.

Function
REQ-014 The FSM SHALL have states IDLE (count 0), ACCUM (count 1..N-1), HOLD (result presented).
REQ-015 Input transfer SHALL occur only when in_valid and in_ready are both high at a rising edge.
REQ-016 in_ready SHALL equal ena and (state != HOLD) and not clear; combinational, no dependence on in_valid.
REQ-017 On each transfer the accumulator SHALL add in_data zero-extended, count SHALL increment, and running max SHALL update to max(max, in_data).
REQ-018 The first transfer from IDLE SHALL load accumulator and max with in_data (no stale contribution).
REQ-019 Transitions: IDLE->ACCUM on transfer (N>1); ACCUM->HOLD on the Nth transfer; HOLD->IDLE on out_valid and out_ready.
REQ-020 out_valid SHALL rise the cycle after the Nth transfer (latency 1) and be high exactly in HOLD.
REQ-021 out_sum, out_avg, out_max SHALL be registered and stable while out_valid is high and out_ready low.
REQ-022 After the output handshake, in_ready SHALL not assert until the following cycle (no same-cycle bypass from HOLD).
REQ-023 Accumulator width SHALL be 8+WIN_LOG2 bits internally; no overflow possible; unused out_sum MSBs SHALL be 0.
REQ-024 clear high SHALL force IDLE, zero count/accumulator/max, and drop out_valid next edge, with priority over transfers and output handshake in the same cycle.
REQ-025 ena low SHALL block transfers but SHALL NOT block the output handshake or clear.
REQ-026 in_data SHALL be ignored when no transfer occurs; out_ready SHALL be ignored outside HOLD.

Reset
REQ-027 rst_n low SHALL immediately (without clock) force IDLE, out_valid=0, out_sum=0, out_avg=0, out_max=0, count 0.
REQ-028 Reset mid-window or in HOLD SHALL discard partial/held results; first window after release starts clean.
REQ-029 in_ready SHALL be 0 while rst_n is low and MAY rise on the first edge after release if ena high.

Verification (WIN_LOG2=2)
REQ-030 Samples 10,20,30,40 back-to-back, out_ready=1 -> next cycle out_valid=1, out_sum=100, out_avg=25, out_max=40; in_ready=0 that cycle.
REQ-031 Four samples of 255 -> out_sum=1020 (0x3FC), out_avg=255, out_max=255.
REQ-032 Result held with out_ready=0 for 5 cycles -> outputs unchanged, in_ready=0, in_valid ignored; out_ready=1 -> out_valid=0 next cycle.
REQ-033 Samples 7,9 then clear, then 1,1,1,1 -> out_sum=4, out_avg=1, out_max=1.
REQ-034 rst_n pulsed low during HOLD -> out_valid=0 immediately; new window 3,3,3,5 -> out_sum=14, out_avg=3, out_max=5.
REQ-035 ena=0 for 3 cycles mid-window with in_valid=1 -> no transfer, count held; window completes correctly after ena=1.
